zz_cpu: RTL and testbench
=========================

// Module: zz_cpu
// PURPOSE
// - Minimal 16-bit multi-cycle CPU; top level of the board design. Fetches instructions and data from external SRAM bank 1.
// - Switch bank `l` is its input port; LED bank `light` is its output port.
// - Eight 16-bit general registers R0..R7, 16-bit PC, word-addressed memory.
// PARAMETERS
// - none (ISA, widths and memory map are fixed)
// PORTS
// - clk       in     1   system clock; all state updates on rising edge
// - rst       in     1   reset, asynchronous, active-low
// - light     out    16  output-port register, written by OUT
// - l         in     16  input port (switches), sampled by IN
// - Ram1Addr  out    18  SRAM word address = {2'b00, addr16}
// - Ram1Data  inout  16  SRAM data; driven only during a store cycle, else 'z
// - Ram1OE    out    1   SRAM output enable, active-low
// - Ram1WE    out    1   SRAM write enable, active-low
// - Ram1EN    out    1   SRAM chip enable, active-low; 0 whenever rst=1
// BEHAVIOUR
// - Reset (rst=0, immediate): PC=0, R0..R7=0, light=0, state=FETCH.
//   Ram1EN=1, Ram1OE=1, Ram1WE=1, Ram1Data='z, Ram1Addr=0.
// - FSM FETCH->EXEC(->MEM)->FETCH. HALT is absorbing until reset.
// - FETCH (1 cycle): Ram1Addr=PC, OE=0, WE=1; IR<=Ram1Data at edge; PC<=PC+1 (wraps 0xFFFF->0).
// - EXEC (1 cycle): decode IR, ALU, register write, branch. Non-memory instrs return to FETCH.
// - MEM (1 cycle, LW/SW only), effective addr EA=rs+sext(IR[5:0]).
//   LW: Ram1Addr=EA, OE=0, rd<=Ram1Data at edge.
//   SW: Ram1Addr=EA, Ram1Data=rd, OE=1, WE=0 for the whole cycle.
// - Latency: 2 cycles per instruction; LW/SW take 3 cycles.
// - Encoding fields: op=IR[15:12], rd=IR[11:9], rs=IR[8:6], rt=IR[5:3].
//   imm8=IR[7:0], imm12=IR[11:0].
// - 0 NOP | 1 LI rd=zext(imm8) | 2 ADD rd=rs+rt | 3 SUB rd=rs-rt
// - 4 AND | 5 OR | 6 ADDI rd=rd+sext(imm8)
// - 7 LW rd=mem[EA] | 8 SW mem[EA]=rd
// - 9 BEQZ: if rd==0, PC=PC+sext(imm8) (PC already incremented)
// - A B: PC=PC+sext(imm12) | B IN rd=l (sampled in EXEC) | C OUT light<=rd
// - D MUL rd=low16(rs*rt) (optional) | E SLL rd=rs<<IR[3:0] | F HALT
// - Arithmetic is modulo 2^16; no flags, no overflow trap. R0 is an ordinary register.
// - Register writes occur at the end of EXEC (MEM for LW); the next FETCH sees the new value.
// - Reset mid-operation: rst=0 during a SW forces WE=1 and Ram1Data='z asynchronously; no partial register update is kept.
// - HALT: OE=1, WE=1, Ram1Data='z, all state frozen; light holds its value.
// CONFIGURATION
// - ZZ_CPU_MUL_EN defined: opcode 0xD performs 16x16 multiply, low 16 bits to rd, single EXEC cycle.
// - ZZ_CPU_MUL_EN undefined: opcode 0xD executes as NOP (2 cycles, no state change); no multiplier inferred.
// TESTING
// - Hold rst=0 -> light=0, OE=WE=EN=1, Ram1Data='z. Release -> first cycle Ram1Addr=0, OE=0.
// - LI R1,5; LI R2,3; ADD R3,R1,R2; OUT R3; HALT -> light=0x0008 by cycle 10.
//   Afterwards OE stays 1 and PC is frozen.
// - LI R1,0x40; LI R2,0xAB; SW R2,R1,1; LW R4,R1,1; OUT R4 ->
//   one WE-low cycle with addr 0x00041, data 0x00AB; light=0x00AB.
// - 0:LI R1,3; 1:ADDI R1,-1; 2:BEQZ R1,+1; 3:B -3; 4:OUT R1; 5:HALT -> loop runs 3 times, light=0x0000.
// - l=0x1234; IN R5; OUT R5 -> light=0x1234. Assert rst mid-SW -> WE returns to 1 same instant.
// - LI R1,6; LI R2,7; MUL R3,R1,R2; OUT R3 -> light=0x002A with ZZ_CPU_MUL_EN, 0x0000 without.

Source files
------------

// File: rtl/zz_cpu.sv
// zz_cpu: 16-bit multi-cycle CPU running from SRAM bank 1, switches on l, LEDs on light.
// Build option: define ZZ_CPU_MUL_EN to give opcode 0xD a single-cycle 16x16 multiply (otherwise NOP).
//
// state | meaning
// FETCH | read instruction at PC from SRAM, PC advances
// EXEC  | decode, ALU, register write, branch, port I/O
// MEM   | LW/SW data access at rs+sext(imm6)
// HALT  | bus idle, everything frozen until reset
module zz_cpu (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] light,
    input  logic [15:0] l,
    output logic [17:0] Ram1Addr,
    inout  wire  [15:0] Ram1Data,
    output logic        Ram1OE,
    output logic        Ram1WE,
    output logic        Ram1EN
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_LI   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_B    = 4'hA;
    localparam logic [3:0] OP_IN   = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_SLL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] regs [8];

    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] rd_val, rs_val, rt_val;
    logic [15:0] sext8, sext12, ea;
    logic [15:0] alu_res;
    logic        alu_we;
    logic        sw_drive;

    assign op     = ir[15:12];
    assign rd     = ir[11:9];
    assign rs     = ir[8:6];
    assign rt     = ir[5:3];
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];
    assign rt_val = regs[rt];
    assign sext8  = {{8{ir[7]}}, ir[7:0]};
    assign sext12 = {{4{ir[11]}}, ir[11:0]};
    assign ea     = rs_val + {{10{ir[5]}}, ir[5:0]};

    always_comb begin
        alu_res = '0;
        alu_we  = 1'b0;
        case (op)
            OP_LI:   begin alu_res = {8'h00, ir[7:0]};  alu_we = 1'b1; end
            OP_ADD:  begin alu_res = rs_val + rt_val;   alu_we = 1'b1; end
            OP_SUB:  begin alu_res = rs_val - rt_val;   alu_we = 1'b1; end
            OP_AND:  begin alu_res = rs_val & rt_val;   alu_we = 1'b1; end
            OP_OR:   begin alu_res = rs_val | rt_val;   alu_we = 1'b1; end
            OP_ADDI: begin alu_res = rd_val + sext8;    alu_we = 1'b1; end
            OP_IN:   begin alu_res = l;                 alu_we = 1'b1; end
`ifdef ZZ_CPU_MUL_EN
            OP_MUL:  begin alu_res = rs_val * rt_val;   alu_we = 1'b1; end
`endif
            OP_SLL:  begin alu_res = rs_val << ir[3:0]; alu_we = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            light <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= Ram1Data;
                    pc    <= pc + 16'd1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    if (alu_we) regs[rd] <= alu_res;
                    case (op)
                        OP_LW, OP_SW: state <= S_MEM;
                        OP_BEQZ:      if (rd_val == 16'h0000) pc <= pc + sext8;
                        OP_B:         pc <= pc + sext12;
                        OP_OUT:       light <= rd_val;
                        OP_HALT:      state <= S_HALT;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (op == OP_LW) regs[rd] <= Ram1Data;
                    state <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

    // Bus strobes decode straight from state and rst so reset releases the SRAM immediately.
    always_comb begin
        Ram1EN   = ~rst;
        Ram1OE   = 1'b1;
        Ram1WE   = 1'b1;
        Ram1Addr = '0;
        if (rst) begin
            Ram1Addr = {2'b00, pc};
            case (state)
                S_FETCH: Ram1OE = 1'b0;
                S_MEM: begin
                    Ram1Addr = {2'b00, ea};
                    if (op == OP_LW) Ram1OE = 1'b0;
                    else             Ram1WE = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sw_drive = rst && (state == S_MEM) && (op == OP_SW);
    assign Ram1Data = sw_drive ? rd_val : 16'hzzzz;

endmodule

// File: tb/tb_zz_cpu.sv
// Scoreboard bench for zz_cpu: expected SRAM writes and halt-time results are queued by the
// driver and consumed by a negedge monitor that watches the SRAM strobes.
module tb_zz_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] l = 16'h0000;
    logic [15:0] light;
    logic [17:0] Ram1Addr;
    wire  [15:0] Ram1Data;
    logic        Ram1OE, Ram1WE, Ram1EN;

    always #5 clk = ~clk;

    zz_cpu dut (
        .clk      (clk),
        .rst      (rst),
        .light    (light),
        .l        (l),
        .Ram1Addr (Ram1Addr),
        .Ram1Data (Ram1Data),
        .Ram1OE   (Ram1OE),
        .Ram1WE   (Ram1WE),
        .Ram1EN   (Ram1EN)
    );

    // SRAM model: image is reloaded into mem while reset is held.
    logic [15:0] image [256];
    logic [15:0] mem   [256];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= image[i];
        end else if (!Ram1EN && !Ram1WE) begin
            mem[Ram1Addr[7:0]] <= Ram1Data;
        end
    end

    assign Ram1Data = (!Ram1EN && !Ram1OE && Ram1WE) ? mem[Ram1Addr[7:0]] : 16'hzzzz;
    pullup (Ram1Data);

    typedef struct {
        logic [15:0] light;
        int          cyc;
    } halt_exp_t;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    halt_exp_t halt_q[$];
    wr_exp_t   wr_q[$];

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Instruction encoders
    function automatic logic [15:0] i_li(logic [2:0] rd, logic [7:0] imm);
        return {4'h1, rd, 1'b0, imm};
    endfunction
    function automatic logic [15:0] i_r(logic [3:0] op, logic [2:0] rd, logic [2:0] rs, logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction
    function automatic logic [15:0] i_imm8(logic [3:0] op, logic [2:0] rd, logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction
    function automatic logic [15:0] i_mem(logic [3:0] op, logic [2:0] rd, logic [2:0] rs, logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction
    function automatic logic [15:0] i_sll(logic [2:0] rd, logic [2:0] rs, logic [3:0] sh);
        return {4'hE, rd, rs, 2'b00, sh};
    endfunction
    function automatic logic [15:0] i_b(logic [11:0] imm);
        return {4'hA, imm};
    endfunction
    localparam logic [15:0] HALT = 16'hF000;

    // Monitor
    int cyc      = 0;
    int run_len  = 0;
    bit halted   = 1'b0;
    int halt_cnt = 0;
    halt_exp_t he;
    wr_exp_t   we;

    always @(negedge clk) begin
        if (!rst) begin
            cyc     = 0;
            run_len = 0;
            halted  = 1'b0;
        end else begin
            cyc++;
            if (halted) check("halt_bus_idle", {30'd0, Ram1OE, Ram1WE}, 32'd3);
            if (!Ram1WE) begin
                run_len = 0;
                if (wr_q.size() == 0) begin
                    check("write_expected", 32'd0, 32'd1);
                end else begin
                    we = wr_q.pop_front();
                    check("write_addr", {14'd0, Ram1Addr}, {14'd0, we.addr});
                    check("write_data", {16'd0, Ram1Data}, {16'd0, we.data});
                end
            end else if (Ram1OE) begin
                run_len++;
            end else begin
                run_len = 0;
            end
            if (run_len == 3 && !halted) begin
                halted = 1'b1;
                halt_cnt++;
                if (halt_q.size() == 0) begin
                    check("halt_expected", 32'd0, 32'd1);
                end else begin
                    he = halt_q.pop_front();
                    check("halt_light", {16'd0, light}, {16'd0, he.light});
                    check("halt_cycle", cyc, he.cyc);
                end
            end
        end
    end

    task automatic clear_image();
        for (int i = 0; i < 256; i++) image[i] = 16'h0000;
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_light"}, {16'd0, light}, 32'd0);
        check({tag, "_oe_we_en"}, {29'd0, Ram1OE, Ram1WE, Ram1EN}, 32'd7);
        check({tag, "_data_released"}, {16'd0, Ram1Data}, 32'h0000FFFF);
        check({tag, "_addr"}, {14'd0, Ram1Addr}, 32'd0);
    endtask

    task automatic start_prog();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("first_fetch_addr", {14'd0, Ram1Addr}, 32'd0);
        check("first_fetch_oe", {31'd0, Ram1OE}, 32'd0);
    endtask

    task automatic wait_halt();
        int start;
        int n;
        start = halt_cnt;
        n = 0;
        while (halt_cnt == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("halt_reached", (halt_cnt != start) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic load_memprog();
        clear_image();
        image[0] = i_li(3'd1, 8'h40);
        image[1] = i_li(3'd2, 8'hAB);
        image[2] = i_mem(4'h8, 3'd2, 3'd1, 6'd1);
        image[3] = i_mem(4'h7, 3'd4, 3'd1, 6'd1);
        image[4] = i_imm8(4'hC, 3'd4, 8'h00);
        image[5] = HALT;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        clear_image();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");

        // LI/ADD/OUT
        clear_image();
        image[0] = i_li(3'd1, 8'd5);
        image[1] = i_li(3'd2, 8'd3);
        image[2] = i_r(4'h2, 3'd3, 3'd1, 3'd2);
        image[3] = i_imm8(4'hC, 3'd3, 8'h00);
        image[4] = HALT;
        halt_q.push_back('{16'h0008, 12});
        start_prog();
        wait_halt();

        // SW then LW through the same SRAM word
        load_memprog();
        wr_q.push_back('{18'h00041, 16'h00AB});
        halt_q.push_back('{16'h00AB, 16});
        start_prog();
        wait_halt();

        // Countdown loop with BEQZ and backward B
        clear_image();
        image[0] = i_li(3'd1, 8'd3);
        image[1] = i_imm8(4'h6, 3'd1, 8'hFF);
        image[2] = i_imm8(4'h9, 3'd1, 8'h01);
        image[3] = i_b(12'hFFD);
        image[4] = i_imm8(4'hC, 3'd1, 8'h00);
        image[5] = HALT;
        halt_q.push_back('{16'h0000, 24});
        start_prog();
        wait_halt();

        // IN from switches
        clear_image();
        l = 16'h1234;
        image[0] = i_imm8(4'hB, 3'd5, 8'h00);
        image[1] = i_imm8(4'hC, 3'd5, 8'h00);
        image[2] = HALT;
        halt_q.push_back('{16'h1234, 8});
        start_prog();
        wait_halt();

        // MUL (NOP when the multiplier is not built)
        clear_image();
        image[0] = i_li(3'd1, 8'd6);
        image[1] = i_li(3'd2, 8'd7);
        image[2] = i_r(4'hD, 3'd3, 3'd1, 3'd2);
        image[3] = i_imm8(4'hC, 3'd3, 8'h00);
        image[4] = HALT;
`ifdef ZZ_CPU_MUL_EN
        halt_q.push_back('{16'h002A, 12});
`else
        halt_q.push_back('{16'h0000, 12});
`endif
        start_prog();
        wait_halt();

        // SUB/AND/OR/SLL/ADDI with wraparound
        clear_image();
        image[0]  = i_li(3'd1, 8'hF0);
        image[1]  = i_li(3'd2, 8'h3C);
        image[2]  = i_r(4'h3, 3'd3, 3'd1, 3'd2);
        image[3]  = i_r(4'h4, 3'd4, 3'd1, 3'd2);
        image[4]  = i_r(4'h5, 3'd5, 3'd1, 3'd2);
        image[5]  = i_sll(3'd6, 3'd3, 4'd4);
        image[6]  = i_r(4'h2, 3'd7, 3'd6, 3'd5);
        image[7]  = i_r(4'h2, 3'd7, 3'd7, 3'd4);
        image[8]  = i_imm8(4'h6, 3'd0, 8'hFF);
        image[9]  = i_r(4'h2, 3'd7, 3'd7, 3'd0);
        image[10] = i_imm8(4'hC, 3'd7, 8'h00);
        image[11] = HALT;
        halt_q.push_back('{16'h0C6B, 26});
        start_prog();
        wait_halt();

        // Reset asserted in the middle of the SW cycle
        load_memprog();
        wr_q.push_back('{18'h00041, 16'h00AB});
        start_prog();
        n = 0;
        while (Ram1WE && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("sw_we_low", {31'd0, Ram1WE}, 32'd0);
        rst = 1'b0;
        #1;
        check("midsw_we", {31'd0, Ram1WE}, 32'd1);
        check("midsw_data_released", {16'd0, Ram1Data}, 32'h0000FFFF);
        repeat (2) @(negedge clk);
        #1;
        reset_checks("midsw_reset");

        check("write_queue_empty", wr_q.size(), 32'd0);
        check("halt_queue_empty", halt_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
